// File: rtl/mem_block_mover.sv
// mem_block_mover: fill/copy engine for a single-port RAM, all outputs registered.
// Optional running checksum of written words is enabled by MEM_BLOCK_MOVER_CHECKSUM_EN.
module mem_block_mover #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_i;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_ram_address;
  logic [DATA_W-1:0] r_ram_in;
  logic              r_ram_load;

  logic [ADDR_W:0]   w_len_sat;
  logic [ADDR_W:0]   w_i_nx;
  logic              w_last;
  logic [ADDR_W-1:0] w_dst_cur;
  logic [ADDR_W-1:0] w_dst_nx;
  logic [ADDR_W-1:0] w_src_nx;

  assign w_len_sat = (len > LEN_MAX) ? LEN_MAX : len;
  assign w_i_nx    = r_i + ONE;
  assign w_last    = (w_i_nx == r_len);
  assign w_dst_cur = r_dst + r_i[ADDR_W-1:0];
  assign w_dst_nx  = r_dst + w_i_nx[ADDR_W-1:0];
  assign w_src_nx  = r_src + w_i_nx[ADDR_W-1:0];

  // Address/data registers are loaded one cycle ahead so each state sees its own values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_src         <= '0;
      r_dst         <= '0;
      r_len         <= '0;
      r_i           <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ram_address <= '0;
      r_ram_in      <= '0;
      r_ram_load    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            if (w_len_sat == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_src <= src_addr;
              r_dst <= dst_addr;
              r_len <= w_len_sat;
              r_i   <= '0;
              if (mode) begin
                r_state       <= S_RD;
                r_ram_address <= src_addr;
                r_ram_load    <= 1'b0;
              end else begin
                r_state       <= S_FILL;
                r_ram_address <= dst_addr;
                r_ram_in      <= fill_data;
                r_ram_load    <= 1'b1;
              end
            end
          end
        end
        S_FILL: begin
          if (w_last) begin
            r_state    <= S_DONE;
            r_ram_load <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_i           <= w_i_nx;
            r_ram_address <= w_dst_nx;
          end
        end
        S_RD: begin
          r_state       <= S_WR;
          r_ram_in      <= ram_out;
          r_ram_address <= w_dst_cur;
          r_ram_load    <= 1'b1;
        end
        S_WR: begin
          r_ram_load <= 1'b0;
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state       <= S_RD;
            r_i           <= w_i_nx;
            r_ram_address <= w_src_nx;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_ram_load <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign ram_address = r_ram_address;
  assign ram_in      = r_ram_in;
  assign ram_load    = r_ram_load;

`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Sums at the edge where the RAM commits the word, so it is final when done rises.
  always_ff @(posedge clk) begin
    if (!rst_n || (r_state == S_IDLE && start)) begin
      r_checksum <= '0;
    end else if (r_ram_load) begin
      r_checksum <= r_checksum + r_ram_in;
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover paired with a 4096x16 RAM model; checks against an array-level reference.
module tb_mem_block_mover;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int NW = 4096;
  localparam int MAXC = 9000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] fill_data = '0;
  logic          busy, done, ram_load;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_in, ram_out;
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] ram [NW];
  logic [DW-1:0] ref_mem [NW];
  logic          clr_mem = 1'b0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int load_cnt = 0;

  mem_block_mover #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
    .busy(busy), .done(done), .ram_address(ram_address), .ram_in(ram_in),
    .ram_load(ram_load), .ram_out(ram_out)
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // ram4096: synchronous write, combinational read
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int k = 0; k < NW; k++) ram[k] <= 16'(k * 40503 + 17);
    end else if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (ram_load) begin
      ram[ram_address] <= ram_in;
    end
  end
  assign ram_out = ram[ram_address];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ram_load) load_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int mem_diffs();
    int d = 0;
    for (int k = 0; k < NW; k++) if (ram[k] !== ref_mem[k]) d++;
    return d;
  endfunction

  task automatic ref_init();
    for (int k = 0; k < NW; k++) ref_mem[k] = 16'(k * 40503 + 17);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    step();
    pre_we = 1'b0;
    ref_mem[a] = v;
  endtask

  // Reference: ascending word-by-word semantics, modulo-4096 addressing, saturated length.
  task automatic model_op(input logic m, input int s, input int d, input int l, input logic [DW-1:0] f,
                          output int exp_lat, output int exp_loads, output logic [DW-1:0] exp_sum);
    int n;
    logic [DW-1:0] w;
    n = (l > NW) ? NW : l;
    exp_sum = '0;
    for (int k = 0; k < n; k++) begin
      w = m ? ref_mem[(s + k) % NW] : f;
      ref_mem[(d + k) % NW] = w;
      exp_sum = exp_sum + w;
    end
    exp_loads = n;
    exp_lat = m ? 2 * n + 1 : n + 1;
  endtask

  task automatic do_op(input logic m, input int s, input int d, input int l, input logic [DW-1:0] f,
                       output int lat, output int loads, output int dones);
    int d0, l0;
    d0 = done_cnt; l0 = load_cnt;
    mode = m; src_addr = AW'(s); dst_addr = AW'(d); len = (AW+1)'(l); fill_data = f;
    start = 1'b1;
    step();
    start = 1'b0;
    mode = ~m; src_addr = ~src_addr; dst_addr = ~dst_addr; fill_data = ~f;
    lat = -1;
    for (int c = 1; c <= MAXC; c++) begin
      if (done) begin lat = c; break; end
      step();
    end
    step();
    step();
    loads = load_cnt - l0;
    dones = done_cnt - d0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr_mem = 1'b1;
    step();
    clr_mem = 1'b0;
    step();
    ref_init();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (ram_load !== 1'b0) begin n_fail++; $display("FAIL reset_load got %b want 0", ram_load); end
    n_checks++; if (ram_address !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 000", ram_address); end
    n_checks++; if (ram_in !== '0) begin n_fail++; $display("FAIL reset_din got %h want 0000", ram_in); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    int lat, loads, dones, el, eld;
    logic [DW-1:0] es;
    model_op(1'b0, 0, 12'h003, 4, 16'h0234, el, eld, es);
    do_op(1'b0, 0, 12'h003, 4, 16'h0234, lat, loads, dones);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL fill_latency got %0d want 5", lat); end
    n_checks++; if (ram[12'h006] !== 16'h0234) begin n_fail++; $display("FAIL fill_last_word got %h want 0234", ram[12'h006]); end
    n_checks++; if (ram[12'h007] !== 16'(7 * 40503 + 17)) begin n_fail++; $display("FAIL fill_after_unchanged got %h want %h", ram[12'h007], 16'(7 * 40503 + 17)); end
    n_checks++; if (mem_diffs() !== 0) begin n_fail++; $display("FAIL fill_mem got %0d diffs want 0", mem_diffs()); end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL fill_done_pulses got %0d want 1", dones); end
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    n_checks++; if (checksum !== 16'h08D0) begin n_fail++; $display("FAIL fill_checksum got %h want 08d0", checksum); end
`endif
  endtask

  task automatic test_copy();
    int lat, loads, dones, el, eld;
    logic [DW-1:0] es;
    preload(12'h013, 16'h1245);
    preload(12'h014, 16'hABC4);
    model_op(1'b1, 12'h013, 12'h0AA, 2, '0, el, eld, es);
    do_op(1'b1, 12'h013, 12'h0AA, 2, 16'h5555, lat, loads, dones);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL copy_latency got %0d want 5", lat); end
    n_checks++; if (ram[12'h0AA] !== 16'h1245) begin n_fail++; $display("FAIL copy_word0 got %h want 1245", ram[12'h0AA]); end
    n_checks++; if (ram[12'h0AB] !== 16'hABC4) begin n_fail++; $display("FAIL copy_word1 got %h want abc4", ram[12'h0AB]); end
    n_checks++; if (mem_diffs() !== 0) begin n_fail++; $display("FAIL copy_mem got %0d diffs want 0", mem_diffs()); end
    n_checks++; if (loads !== 2) begin n_fail++; $display("FAIL copy_loads got %0d want 2", loads); end
  endtask

  task automatic test_wrap();
    int lat, loads, dones, el, eld;
    logic [DW-1:0] es;
    model_op(1'b0, 0, 12'hFFE, 4, 16'h0001, el, eld, es);
    do_op(1'b0, 0, 12'hFFE, 4, 16'h0001, lat, loads, dones);
    n_checks++; if (ram[12'h000] !== 16'h0001) begin n_fail++; $display("FAIL wrap_word000 got %h want 0001", ram[12'h000]); end
    n_checks++; if (ram[12'h001] !== 16'h0001) begin n_fail++; $display("FAIL wrap_word001 got %h want 0001", ram[12'h001]); end
    n_checks++; if (mem_diffs() !== 0) begin n_fail++; $display("FAIL wrap_mem got %0d diffs want 0", mem_diffs()); end
  endtask

  task automatic test_zero_len();
    int lat, loads, dones;
    do_op(1'b0, 0, 12'h100, 0, 16'hDEAD, lat, loads, dones);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zero_latency got %0d want 1", lat); end
    n_checks++; if (loads !== 0) begin n_fail++; $display("FAIL zero_loads got %0d want 0", loads); end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL zero_done_pulses got %0d want 1", dones); end
    n_checks++; if (mem_diffs() !== 0) begin n_fail++; $display("FAIL zero_mem got %0d diffs want 0", mem_diffs()); end
  endtask

  task automatic test_saturate();
    int lat, loads, dones, el, eld;
    logic [DW-1:0] es;
    model_op(1'b0, 0, 12'h777, 8191, 16'h3C3C, el, eld, es);
    do_op(1'b0, 0, 12'h777, 8191, 16'h3C3C, lat, loads, dones);
    n_checks++; if (lat !== 4097) begin n_fail++; $display("FAIL sat_latency got %0d want 4097", lat); end
    n_checks++; if (loads !== 4096) begin n_fail++; $display("FAIL sat_loads got %0d want 4096", loads); end
    n_checks++; if (mem_diffs() !== 0) begin n_fail++; $display("FAIL sat_mem got %0d diffs want 0", mem_diffs()); end
    rst_n = 1'b0; clr_mem = 1'b1;
    step();
    clr_mem = 1'b0; rst_n = 1'b1;
    step();
    ref_init();
  endtask

  task automatic test_busy_start();
    int lat, d0, l0, el, eld;
    logic [DW-1:0] es;
    model_op(1'b1, 12'h200, 12'h300, 6, '0, el, eld, es);
    d0 = done_cnt; l0 = load_cnt;
    mode = 1'b1; src_addr = 12'h200; dst_addr = 12'h300; len = 13'd6; fill_data = 16'h0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    mode = 1'b0; src_addr = 12'h500; dst_addr = 12'h600; len = 13'd3; fill_data = 16'hBEEF;
    start = 1'b1;
    step();
    start = 1'b0;
    lat = -1;
    for (int c = 4; c <= MAXC; c++) begin
      if (done) begin lat = c; break; end
      step();
    end
    for (int k = 0; k < 4; k++) step();
    n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL busy_latency got %0d want 13", lat); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL busy_done_pulses got %0d want 1", done_cnt - d0); end
    n_checks++; if (load_cnt - l0 !== 6) begin n_fail++; $display("FAIL busy_loads got %0d want 6", load_cnt - l0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle_after got %b want 0", busy); end
    n_checks++; if (mem_diffs() !== 0) begin n_fail++; $display("FAIL busy_mem got %0d diffs want 0", mem_diffs()); end
  endtask

  task automatic test_abort();
    int d0, el, eld;
    logic [DW-1:0] es;
    // Reset sampled at the edge closing the 2nd write: words 0 and 1 land, the 3rd never does.
    model_op(1'b0, 0, 12'h110, 2, 16'h7E57, el, eld, es);
    d0 = done_cnt;
    mode = 1'b0; dst_addr = 12'h110; len = 13'd8; fill_data = 16'h7E57;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_checks++; if (ram_load !== 1'b0) begin n_fail++; $display("FAIL abort_load got %b want 0", ram_load); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) step();
    n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL abort_done_pulses got %0d want 0", done_cnt - d0); end
    n_checks++; if (ram[12'h111] !== 16'h7E57) begin n_fail++; $display("FAIL abort_word1 got %h want 7e57", ram[12'h111]); end
    n_checks++; if (mem_diffs() !== 0) begin n_fail++; $display("FAIL abort_mem got %0d diffs want 0", mem_diffs()); end
  endtask

  task automatic test_random();
    int lat, loads, dones, el, eld, s, d, l;
    logic m;
    logic [DW-1:0] f, es;
    for (int t = 0; t < 16; t++) begin
      m = 1'($urandom_range(0, 1));
      s = int'($urandom_range(0, NW - 1));
      d = (t % 3 == 0) ? (s + int'($urandom_range(0, 5))) % NW : int'($urandom_range(0, NW - 1));
      if (t % 5 == 1) d = (s + NW - int'($urandom_range(1, 4))) % NW;
      l = int'($urandom_range(0, 24));
      f = 16'($urandom);
      model_op(m, s, d, l, f, el, eld, es);
      do_op(m, s, d, l, f, lat, loads, dones);
      n_checks++; if (lat !== el) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", t, lat, el); end
      n_checks++; if (loads !== eld) begin n_fail++; $display("FAIL rand%0d_loads got %0d want %0d", t, loads, eld); end
      n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL rand%0d_done_pulses got %0d want 1", t, dones); end
      n_checks++; if (mem_diffs() !== 0) begin n_fail++; $display("FAIL rand%0d_mem got %0d diffs want 0", t, mem_diffs()); end
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
      n_checks++; if (checksum !== es) begin n_fail++; $display("FAIL rand%0d_checksum got %h want %h", t, checksum, es); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_wrap();
    test_zero_len();
    test_busy_start();
    test_abort();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
